// File: rtl/arb_pkg.sv
// =============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the two-requester memory port
//               arbiter (FSM states, owner encoding, default access length).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package arb_pkg;

    localparam int c_wait_cyc_def = 1;
    localparam int c_wcnt_w       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// =============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and shared-memory bus bundle. The arbiter uses the
//               slave modport; requesters and the memory model use master.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );

endinterface

`default_nettype wire

// File: rtl/arb_wait_counter.sv
// =============================================================================
// Module      : arb_wait_counter
// Description : Loadable down-counter timing the ACCESS phase; o_done flags
//               the final access cycle.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module arb_wait_counter #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_dec,
    output      logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Count of one means this is the last cycle the memory is being accessed
    assign o_done = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// =============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates a fetch and a load/store requester onto one shared
//               memory port. Define ARB_ROUND_ROBIN_EN for alternating grants;
//               otherwise the data requester has fixed priority.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = c_wait_cyc_def
) (
    input wire logic          clk,
    input wire logic          rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_open;
    logic              w_pick_d;
    logic              w_gnt_if;
    logic              w_gnt_d;
    logic              w_load;
    logic              w_in_access;
    logic              w_wait_done;

    assign w_open      = (r_state == IDLE) || (r_state == RESP);
    assign w_in_access = (r_state == ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t r_last;

    // Contention goes to whoever was not served last
    assign w_pick_d = bus.d_req && (!bus.if_req || (r_last == OWN_IF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= OWN_IF;
        end else if (w_load) begin
            r_last <= w_gnt_d ? OWN_D : OWN_IF;
        end
    end
`else
    assign w_pick_d = bus.d_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_if    = 1'b0;
        w_gnt_d     = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                if (bus.d_req || bus.if_req) begin
                    w_state_nxt = ACCESS;
                    w_gnt_d     = w_pick_d;
                    w_gnt_if    = !w_pick_d;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (w_wait_done) begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_load = w_gnt_if || w_gnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request attributes are frozen at grant; requesters are ignored afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_load) begin
            r_owner <= w_gnt_d ? OWN_D : OWN_IF;
            r_we    <= w_gnt_d && bus.d_we;
            r_addr  <= w_gnt_d ? bus.d_addr : bus.if_addr;
            r_wdata <= bus.d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_in_access && w_wait_done) begin
            if (r_owner == OWN_IF) begin
                r_if_rdata <= bus.mem_rdata;
            end else if (!r_we) begin
                r_d_rdata <= bus.mem_rdata;
            end
        end
    end

    arb_wait_counter #(
        .CNT_W (c_wcnt_w)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_wcnt_w'(WAIT_CYC)),
        .i_dec      (w_in_access),
        .o_done     (w_wait_done)
    );

    // mem_en derives from the state register so reset drops it asynchronously
    assign bus.mem_en    = w_in_access;
    assign bus.mem_we    = w_in_access && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.if_gnt    = w_gnt_if;
    assign bus.d_gnt     = w_gnt_d;
    assign bus.if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
    assign bus.d_rvalid  = (r_state == RESP) && (r_owner == OWN_D);
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;

    assign bus.stall = (bus.if_req && !bus.if_rvalid) || (bus.d_req && !bus.d_rvalid);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// =============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench: WAIT_CYC=1 and WAIT_CYC=3 instances driven in
//               sequence, with hand-computed expectations.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [3:0] order;
    logic [3:0] order_exp;
    int   ng;
    int   seen;

    mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b3 ();

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .WAIT_CYC(1)) u_dut1 (
        .clk (clk),
        .rst (rst_n),
        .bus (b1)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .WAIT_CYC(3)) u_dut3 (
        .clk (clk),
        .rst (rst_n),
        .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0;
        b1.d_addr = '0; b1.d_wdata = '0; b1.mem_rdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0;
        b3.d_addr = '0; b3.d_wdata = '0; b3.mem_rdata = '0;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en",   b1.mem_en,   1'b0);
        chk("rst_if_gnt",   b1.if_gnt,   1'b0);
        chk("rst_if_rvld",  b1.if_rvalid, 1'b0);
        chk("rst_if_rdata", b1.if_rdata, 32'h0);
        chk("rst_mem_addr", b3.mem_addr, 10'h0);
        chk("rst_d_rdata",  b3.d_rdata,  32'h0);
        rst_n = 1'b1;
        tick();

        // ---- single fetch, WAIT_CYC=1
        b1.if_req = 1; b1.if_addr = 10'h010; b1.mem_rdata = 32'h00000013;
        #1;
        chk("t1_if_gnt", b1.if_gnt, 1'b1);
        chk("t1_d_gnt",  b1.d_gnt,  1'b0);
        chk("t1_stall",  b1.stall,  1'b1);
        tick();
        b1.if_req = 0; b1.if_addr = 10'h3FF;
        #1;
        chk("t1_mem_en",   b1.mem_en,    1'b1);
        chk("t1_mem_addr", b1.mem_addr,  10'h010);
        chk("t1_mem_we",   b1.mem_we,    1'b0);
        chk("t1_rvld_acc", b1.if_rvalid, 1'b0);
        tick();
        chk("t1_if_rvld",   b1.if_rvalid, 1'b1);
        chk("t1_if_rdata",  b1.if_rdata,  32'h00000013);
        chk("t1_d_rvld",    b1.d_rvalid,  1'b0);
        chk("t1_en_resp",   b1.mem_en,    1'b0);
        chk("t1_addr_hold", b1.mem_addr,  10'h010);
        tick();
        chk("t1_rvld_drop", b1.if_rvalid, 1'b0);
        chk("t1_rdata_hold", b1.if_rdata, 32'h00000013);

        // ---- contention: data load wins first, fetch granted in RESP
        b1.if_req = 1; b1.if_addr = 10'h040;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 10'h020;
        b1.mem_rdata = 32'hA5A50020;
        #1;
        chk("t2_d_gnt",  b1.d_gnt,  1'b1);
        chk("t2_if_gnt", b1.if_gnt, 1'b0);
        tick();
        b1.d_req = 0;
        #1;
        chk("t2_mem_addr_d", b1.mem_addr, 10'h020);
        chk("t2_no_gnt_acc", b1.if_gnt,   1'b0);
        chk("t2_stall",      b1.stall,    1'b1);
        tick();
        b1.mem_rdata = 32'h11110040;
        #1;
        chk("t2_d_rvld",    b1.d_rvalid,  1'b1);
        chk("t2_d_rdata",   b1.d_rdata,   32'hA5A50020);
        chk("t2_if_gnt_rs", b1.if_gnt,    1'b1);
        chk("t2_if_rvld0",  b1.if_rvalid, 1'b0);
        tick();
        b1.if_req = 0;
        #1;
        chk("t2_mem_addr_if", b1.mem_addr, 10'h040);
        tick();
        chk("t2_if_rvld",  b1.if_rvalid, 1'b1);
        chk("t2_if_rdata", b1.if_rdata,  32'h11110040);
        chk("t2_d_hold",   b1.d_rdata,   32'hA5A50020);
        tick();

        // ---- continuous contention, record four grants (bit=1 means data)
        b1.if_req = 1; b1.d_req = 1; b1.d_we = 0;
        #1;
        order = 4'b0000;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            if (b1.d_gnt) begin
                order[ng] = 1'b1;
                ng++;
            end else if (b1.if_gnt) begin
                order[ng] = 1'b0;
                ng++;
            end
            if (ng < 4) tick();
        end
`ifdef ARB_ROUND_ROBIN_EN
        order_exp = 4'b0101;
`else
        order_exp = 4'b1111;
`endif
        chk("t3_grant_cnt", ng, 4);
        chk("t3_order", order, order_exp);
        b1.if_req = 0; b1.d_req = 0;
        tick(); tick(); tick();

        // ---- WAIT_CYC=3: load to seed d_rdata, latency T+4
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 10'h005; b3.mem_rdata = 32'h12345678;
        #1;
        chk("t4_ld_gnt", b3.d_gnt, 1'b1);
        tick();
        b3.d_req = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t4_ld_mem_en", b3.mem_en,   1'b1);
            chk("t4_ld_rvld0",  b3.d_rvalid, 1'b0);
            tick();
        end
        chk("t4_ld_rvld",  b3.d_rvalid, 1'b1);
        chk("t4_ld_rdata", b3.d_rdata,  32'h12345678);
        tick();
        chk("t4_ld_rvld_drop", b3.d_rvalid, 1'b0);

        // ---- store to top address, inputs scrambled after grant
        b3.d_req = 1; b3.d_we = 1; b3.d_addr = 10'h3FF; b3.d_wdata = 32'hDEADBEEF;
        b3.mem_rdata = 32'hCAFEF00D;
        #1;
        chk("t4_st_gnt", b3.d_gnt, 1'b1);
        tick();
        b3.d_req = 0; b3.d_we = 0; b3.d_addr = 10'h000; b3.d_wdata = 32'h0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t4_st_mem_we",    b3.mem_we,    1'b1);
            chk("t4_st_mem_addr",  b3.mem_addr,  10'h3FF);
            chk("t4_st_mem_wdata", b3.mem_wdata, 32'hDEADBEEF);
            chk("t4_st_rvld0",     b3.d_rvalid,  1'b0);
            tick();
        end
        chk("t4_st_rvld",   b3.d_rvalid, 1'b1);
        chk("t4_st_rdata",  b3.d_rdata,  32'h12345678);
        chk("t4_st_we_off", b3.mem_we,   1'b0);
        chk("t4_st_en_off", b3.mem_en,   1'b0);
        tick();
        chk("t4_st_rvld_drop", b3.d_rvalid, 1'b0);

        // ---- reset in the second ACCESS cycle of a load
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 10'h077; b3.mem_rdata = 32'h0BADF00D;
        #1;
        chk("t5_gnt", b3.d_gnt, 1'b1);
        tick();
        b3.d_req = 0;
        tick();
        chk("t5_en_acc2", b3.mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_en_async", b3.mem_en,   1'b0);
        chk("t5_addr_rst", b3.mem_addr, 10'h000);
        chk("t5_rdata_rst", b3.d_rdata, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (b3.d_rvalid) seen++;
        end
        chk("t5_no_rvalid", seen, 0);
        b3.if_req = 1; b3.if_addr = 10'h0AA; b3.mem_rdata = 32'h00000055;
        #1;
        chk("t5_post_if_gnt", b3.if_gnt, 1'b1);
        chk("t5_post_d_gnt",  b3.d_gnt,  1'b0);
        tick();
        b3.if_req = 0;
        #1;
        repeat (3) tick();
        chk("t5_post_rvld",  b3.if_rvalid, 1'b1);
        chk("t5_post_rdata", b3.if_rdata,  32'h00000055);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter WAIT_CYC, default 1, memory access cycles; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch requester wants a read.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 d_req  in  1  load/store requester wants access.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  one-cycle pulse; load data valid or store complete.
REQ-017 d_rdata  out  DATA_W  load data.
REQ-018 mem_en, mem_we  out  1 each  shared memory port enable and write enable.
REQ-019 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  shared memory port address and write data.
REQ-020 mem_rdata  in  DATA_W  shared memory read data, valid in the last ACCESS cycle.
REQ-021 stall  out  1  processor hold: high while any request is pending but not yet answered.

Function
REQ-022 FSM states are IDLE, ACCESS and RESP.
REQ-023 IDLE or RESP with any request: assert exactly one gnt combinationally in that cycle, capture owner/addr/we/wdata at the edge, and go to ACCESS.
REQ-024 IDLE or RESP with no request: go to / stay in IDLE.
REQ-025 ACCESS: mem_en=1 and mem_we/mem_addr/mem_wdata are driven from the captured registers for exactly WAIT_CYC cycles, counted by a wait counter.
REQ-026 Last ACCESS cycle: mem_rdata is registered into the owner's rdata, and the state goes to RESP.
REQ-027 RESP: the owner's rvalid is 1 for one cycle; the other rvalid stays 0.
REQ-028 Latency: grant in cycle T gives rvalid in cycle T+WAIT_CYC+1; back-to-back grants every WAIT_CYC+1 cycles.
REQ-029 No grant in ACCESS; requests wait with gnt=0.
REQ-030 Requester inputs are ignored after grant; a dropped or changed req does not affect the transfer in flight.
REQ-031 For a store, mem_we=1 in every ACCESS cycle, d_rvalid pulses as the write acknowledge, and d_rdata holds its previous value.
REQ-032 rdata outputs hold their value until the next response to the same owner.
REQ-033 stall = (if_req & ~if_rvalid) | (d_req & ~d_rvalid).
REQ-034 Outside ACCESS, mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last captured values.

Reset
REQ-035 rst low forces state IDLE, wait counter 0, every gnt/rvalid/mem_en/mem_we 0, every rdata/mem_addr/mem_wdata 0, and round-robin pointer = fetch-last (data wins next).
REQ-036 A reset during ACCESS aborts the transfer: no rvalid is generated, and mem_en falls asynchronously.

Configuration
REQ-037 Macro ARB_ROUND_ROBIN_EN.
REQ-038 Defined: on simultaneous if_req and d_req, the grant alternates, favouring the requester not served last.
REQ-039 Undefined: fixed priority, d_req always wins over if_req.
REQ-040 With only one request present, that request is granted regardless of the macro.

Structure
REQ-041 Package arb_pkg holds the state enum (IDLE/ACCESS/RESP), the owner enum (OWN_IF/OWN_D) and the WAIT_CYC default constant.
REQ-042 Sub-module arb_wait_counter (load, count-down, done flag) holds the ACCESS cycle count; everything else stays in mem_port_arbiter.

Verification
REQ-043 WAIT_CYC=1, if_req with if_addr=0x010 and mem_rdata=0x00000013 -> if_gnt in T, mem_en in T+1, if_rvalid with if_rdata=0x00000013 in T+2.
REQ-044 Fixed priority, if_req and d_req (load, addr 0x020) together -> d_gnt first, if_gnt in the RESP cycle of the load, d_rvalid before if_rvalid.
REQ-045 ARB_ROUND_ROBIN_EN, both requesting continuously for 4 grants -> grant order D, IF, D, IF.
REQ-046 Store d_we=1, addr 0x3FF, wdata 0xDEADBEEF, WAIT_CYC=3 -> mem_we=1 for 3 cycles with mem_addr=0x3FF, then a d_rvalid pulse, and d_rdata unchanged.
REQ-047 rst low in the 2nd ACCESS cycle of a load -> mem_en is 0 immediately, no d_rvalid is ever produced, and the first request after release is granted normally.
